// File: rtl/wb_dma_pkg.sv
// wb_dma_pkg: register offsets, CTRL bit indices and FSM states shared by the wb_dma_copy slice
package wb_dma_pkg;
  localparam logic [3:0] OFF_SRC  = 4'h0;
  localparam logic [3:0] OFF_DST  = 4'h4;
  localparam logic [3:0] OFF_LEN  = 4'h8;
  localparam logic [3:0] OFF_CTRL = 4'hC;
  localparam int CTRL_START  = 0;
  localparam int CTRL_BUSY   = 1;
  localparam int CTRL_DONE   = 2;
  localparam int CTRL_ERR    = 3;
  localparam int CTRL_IRQ_EN = 4;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH, ABORT} state_t;
endpackage

// File: rtl/wb_dma_regs.sv
// wb_dma_regs: register responder (SRC/DST/LEN/CTRL); irq_o exists only when WB_DMA_IRQ_EN is defined
module wb_dma_regs
  import wb_dma_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h1000_8020,
  parameter int          LEN_W    = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             s_wb_cyc_i,
  input  logic             s_wb_stb_i,
  input  logic             s_wb_we_i,
  input  logic [31:0]      s_wb_adr_i,
  input  logic [31:0]      s_wb_dat_i,
  input  logic [3:0]       s_wb_sel_i,
  output logic             s_wb_stall_o,
  output logic             s_wb_ack_o,
  output logic [31:0]      s_wb_dat_o,
  output logic             s_wb_err_o,
  input  logic             busy,
  input  logic             done_set,
  input  logic             err_set,
  output logic             start,
  output logic [31:0]      src,
  output logic [31:0]      dst,
  output logic [LEN_W-1:0] len
`ifdef WB_DMA_IRQ_EN
  ,
  output logic             irq_o
`endif
);
  logic [31:0] off, ctrl_rd, rd_data;
  logic req, hit, wr, wr_ctrl, done, err, irq_en;
  assign off = s_wb_adr_i - BASE_ADR;
  assign req = s_wb_cyc_i & s_wb_stb_i;
  assign hit = (off[31:4] == '0) && (off[1:0] == 2'b00) && (s_wb_sel_i == 4'hF);
  assign wr = req & hit & s_wb_we_i;
  assign wr_ctrl = wr && (off[3:0] == OFF_CTRL);
  assign s_wb_stall_o = 1'b0;
  // read mux; START always reads back as 0
  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_BUSY] = busy;
    ctrl_rd[CTRL_DONE] = done;
    ctrl_rd[CTRL_ERR] = err;
    ctrl_rd[CTRL_IRQ_EN] = irq_en;
    rd_data = off[3:0] == OFF_SRC ? src : off[3:0] == OFF_DST ? dst :
              off[3:0] == OFF_LEN ? 32'(len) : ctrl_rd;
  end
  // single-cycle ack/err, register writes (config frozen while busy), W1C status
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s_wb_ack_o <= 1'b0;
      s_wb_err_o <= 1'b0;
      s_wb_dat_o <= '0;
      start <= 1'b0;
      src <= '0;
      dst <= '0;
      len <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      s_wb_ack_o <= req & hit;
      s_wb_err_o <= req & ~hit;
      s_wb_dat_o <= (req & hit & ~s_wb_we_i) ? rd_data : '0;
      start <= wr_ctrl & s_wb_dat_i[CTRL_START] & ~busy;
      done <= done_set | (done & ~(wr_ctrl & s_wb_dat_i[CTRL_DONE]));
      err <= err_set | (err & ~(wr_ctrl & s_wb_dat_i[CTRL_ERR]));
      if (wr && !busy && off[3:0] == OFF_SRC) src <= {s_wb_dat_i[31:2], 2'b00};
      if (wr && !busy && off[3:0] == OFF_DST) dst <= {s_wb_dat_i[31:2], 2'b00};
      if (wr && !busy && off[3:0] == OFF_LEN) len <= s_wb_dat_i[LEN_W-1:0];
    end
  end
`ifdef WB_DMA_IRQ_EN
  // interrupt enable bit and registered interrupt line
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_en <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= s_wb_dat_i[CTRL_IRQ_EN];
      irq_o <= irq_en & (done | err);
    end
  end
`else
  assign irq_en = 1'b0;
`endif
endmodule

// File: rtl/wb_dma_copy.sv
// wb_dma_copy: Wishbone word-copy initiator (SRC->DST, LEN words); define WB_DMA_IRQ_EN to add irq_o
module wb_dma_copy
  import wb_dma_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h1000_8020,
  parameter int          LEN_W    = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        s_wb_cyc_i,
  input  logic        s_wb_stb_i,
  input  logic        s_wb_we_i,
  input  logic [31:0] s_wb_adr_i,
  input  logic [31:0] s_wb_dat_i,
  input  logic [3:0]  s_wb_sel_i,
  output logic        s_wb_stall_o,
  output logic        s_wb_ack_o,
  output logic [31:0] s_wb_dat_o,
  output logic        s_wb_err_o,
  output logic        m_wb_cyc_o,
  output logic        m_wb_stb_o,
  output logic        m_wb_we_o,
  output logic [31:0] m_wb_adr_o,
  output logic [31:0] m_wb_dat_o,
  output logic [3:0]  m_wb_sel_o,
  input  logic        m_wb_stall_i,
  input  logic        m_wb_ack_i,
  input  logic [31:0] m_wb_dat_i,
  input  logic        m_wb_err_i
`ifdef WB_DMA_IRQ_EN
  ,
  output logic        irq_o
`endif
);
  state_t state;
  logic start, busy, done_set, err_set;
  logic [31:0] src, dst, cur_src, cur_dst;
  logic [LEN_W-1:0] len, rem;
  assign busy = state != IDLE;
  assign done_set = state == FINISH || (state == IDLE && start && len == '0);
  assign err_set = state == ABORT;
  assign m_wb_sel_o = 4'hF;
  wb_dma_regs #(.BASE_ADR(BASE_ADR), .LEN_W(LEN_W)) u_regs (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .s_wb_cyc_i(s_wb_cyc_i),
    .s_wb_stb_i(s_wb_stb_i),
    .s_wb_we_i(s_wb_we_i),
    .s_wb_adr_i(s_wb_adr_i),
    .s_wb_dat_i(s_wb_dat_i),
    .s_wb_sel_i(s_wb_sel_i),
    .s_wb_stall_o(s_wb_stall_o),
    .s_wb_ack_o(s_wb_ack_o),
    .s_wb_dat_o(s_wb_dat_o),
    .s_wb_err_o(s_wb_err_o),
    .busy(busy),
    .done_set(done_set),
    .err_set(err_set),
    .start(start),
    .src(src),
    .dst(dst),
    .len(len)
`ifdef WB_DMA_IRQ_EN
    ,
    .irq_o(irq_o)
`endif
  );
  // copy FSM; request states spend their first cycle with cyc low so every beat is its own bus cycle
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      m_wb_cyc_o <= 1'b0;
      m_wb_stb_o <= 1'b0;
      m_wb_we_o <= 1'b0;
      m_wb_adr_o <= '0;
      m_wb_dat_o <= '0;
      cur_src <= '0;
      cur_dst <= '0;
      rem <= '0;
    end else begin
      case (state)
        IDLE: if (start && len != '0) begin
          state <= RD_REQ;
          cur_src <= src;
          cur_dst <= dst;
          rem <= len;
        end
        RD_REQ: if (!m_wb_cyc_o) begin
          m_wb_cyc_o <= 1'b1;
          m_wb_stb_o <= 1'b1;
          m_wb_we_o <= 1'b0;
          m_wb_adr_o <= cur_src;
        end else if (!m_wb_stall_i) begin
          m_wb_stb_o <= 1'b0;
          state <= RD_WAIT;
        end
        RD_WAIT: if (m_wb_err_i) begin
          m_wb_cyc_o <= 1'b0;
          state <= ABORT;
        end else if (m_wb_ack_i) begin
          m_wb_cyc_o <= 1'b0;
          m_wb_dat_o <= m_wb_dat_i;
          state <= WR_REQ;
        end
        WR_REQ: if (!m_wb_cyc_o) begin
          m_wb_cyc_o <= 1'b1;
          m_wb_stb_o <= 1'b1;
          m_wb_we_o <= 1'b1;
          m_wb_adr_o <= cur_dst;
        end else if (!m_wb_stall_i) begin
          m_wb_stb_o <= 1'b0;
          state <= WR_WAIT;
        end
        WR_WAIT: if (m_wb_err_i) begin
          m_wb_cyc_o <= 1'b0;
          m_wb_we_o <= 1'b0;
          state <= ABORT;
        end else if (m_wb_ack_i) begin
          m_wb_cyc_o <= 1'b0;
          m_wb_we_o <= 1'b0;
          cur_src <= cur_src + 32'd4;
          cur_dst <= cur_dst + 32'd4;
          rem <= rem - LEN_W'(1);
          state <= rem == LEN_W'(1) ? FINISH : RD_REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_dma_copy.sv
// tb_wb_dma_copy: scoreboard bench for wb_dma_copy with a stalling/erroring memory model
module tb_wb_dma_copy;
  localparam logic [31:0] BASE = 32'h1000_8020;
  typedef struct packed {logic we; logic [31:0] adr; logic [31:0] dat;} op_t;
  logic clk = 1'b0, rst = 1'b1;
  logic s_cyc = 1'b0, s_stb = 1'b0, s_we = 1'b0;
  logic [31:0] s_adr = '0, s_dat_w = '0;
  logic [3:0] s_sel = 4'hF;
  logic s_stall, s_ack, s_err;
  logic [31:0] s_dat_r;
  logic m_cyc, m_stb, m_we;
  logic [31:0] m_adr, m_dat_o;
  logic [3:0] m_sel;
  logic m_stall;
  logic m_ack = 1'b0, m_err = 1'b0;
  logic [31:0] m_dat_i = '0;
`ifdef WB_DMA_IRQ_EN
  logic irq;
`endif
  int checks = 0, errors = 0;
  logic [31:0] mem [0:1023];
  logic [31:0] pat [0:15];
  op_t obs_q[$], exp_q[$];
  int stall_cycles = 0, err_on_read = 0, rd_count = 0, wr_count = 0, scnt = 0;
  int cyc_rises = 0, stall_seen = 0, adr_changes = 0, stb_drops = 0;
  logic prev_cyc = 1'b0, held = 1'b0, cyc_after_err = 1'bx;
  logic [31:0] held_adr = '0;

  always #5 clk = ~clk;

  wb_dma_copy dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .s_wb_cyc_i(s_cyc), .s_wb_stb_i(s_stb), .s_wb_we_i(s_we), .s_wb_adr_i(s_adr),
    .s_wb_dat_i(s_dat_w), .s_wb_sel_i(s_sel), .s_wb_stall_o(s_stall), .s_wb_ack_o(s_ack),
    .s_wb_dat_o(s_dat_r), .s_wb_err_o(s_err),
    .m_wb_cyc_o(m_cyc), .m_wb_stb_o(m_stb), .m_wb_we_o(m_we), .m_wb_adr_o(m_adr),
    .m_wb_dat_o(m_dat_o), .m_wb_sel_o(m_sel), .m_wb_stall_i(m_stall), .m_wb_ack_i(m_ack),
    .m_wb_dat_i(m_dat_i), .m_wb_err_i(m_err)
`ifdef WB_DMA_IRQ_EN
    , .irq_o(irq)
`endif
  );

  assign m_stall = m_stb && (scnt < stall_cycles);

  always @(posedge clk) begin
    m_ack <= 1'b0;
    m_err <= 1'b0;
    scnt <= (m_stb && m_stall) ? scnt + 1 : 0;
    if (m_cyc && !prev_cyc) cyc_rises++;
    prev_cyc = m_cyc;
    if (m_stb && m_stall) stall_seen++;
    if (m_stb) begin
      if (held && m_adr !== held_adr) adr_changes++;
      held = m_stall;
      held_adr = m_adr;
    end else begin
      if (held) stb_drops++;
      held = 1'b0;
    end
    if (m_cyc && m_stb && !m_stall) begin
      if (!m_we) begin
        rd_count++;
        obs_q.push_back({1'b0, m_adr, mem[m_adr[11:2]]});
        if (rd_count == err_on_read) m_err <= 1'b1;
        else begin
          m_ack <= 1'b1;
          m_dat_i <= mem[m_adr[11:2]];
        end
      end else begin
        mem[m_adr[11:2]] = m_dat_o;
        wr_count++;
        obs_q.push_back({1'b1, m_adr, m_dat_o});
        m_ack <= 1'b1;
      end
    end
  end

  always @(posedge clk) if (m_err) begin
    @(negedge clk);
    cyc_after_err = m_cyc;
  end

  task automatic reg_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_adr = a; s_dat_w = d;
    @(negedge clk);
    s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
  endtask

  task automatic reg_rd(input logic [31:0] a, output logic [31:0] d, output logic k, output logic e);
    @(negedge clk);
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = a;
    @(negedge clk);
    s_cyc = 1'b0; s_stb = 1'b0;
    d = s_dat_r; k = s_ack; e = s_err;
  endtask

  task automatic wait_idle(output logic [31:0] ctrl, output bit timeout);
    logic k, e;
    timeout = 1'b1;
    for (int i = 0; i < 300; i++) begin
      reg_rd(BASE + 32'hC, ctrl, k, e);
      if (!ctrl[1]) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic setup_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    reg_wr(BASE + 32'h0, s);
    reg_wr(BASE + 32'h4, d);
    reg_wr(BASE + 32'h8, 32'(n));
    reg_wr(BASE + 32'hC, 32'hC);
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      pat[i] = $urandom;
      mem[(s >> 2) + i] = pat[i];
      mem[(d >> 2) + i] = 32'hDEAD_0000 + i;
      exp_q.push_back({1'b0, s + 32'(4 * i), pat[i]});
      exp_q.push_back({1'b1, d + 32'(4 * i), pat[i]});
    end
    rd_count = 0; wr_count = 0; cyc_rises = 0; stall_seen = 0;
    adr_changes = 0; stb_drops = 0; cyc_after_err = 1'bx;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic k, e;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_ack, s_err, s_stall, s_dat_r, m_cyc, m_stb, m_we, m_adr, m_dat_o} !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero outputs, required all 0");
    end
    checks++;
    if (m_sel !== 4'hF) begin errors++; $display("FAIL reset_sel got %h required f", m_sel); end
    rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      reg_rd(BASE + 32'(4 * r), d, k, e);
      checks++;
      if (d !== 32'h0 || k !== 1'b1 || e !== 1'b0) begin
        errors++; $display("FAIL reset_reg%0d got dat=%h ack=%b err=%b required 0/1/0", r, d, k, e);
      end
    end
  endtask

  task automatic test_regport;
    logic [31:0] d;
    logic k, e;
    reg_rd(BASE + 32'h10, d, k, e);
    checks++;
    if (d !== 32'h0 || k !== 1'b0 || e !== 1'b1) begin
      errors++; $display("FAIL unmapped_read got dat=%h ack=%b err=%b required 0/0/1", d, k, e);
    end
    reg_wr(BASE + 32'h0, 32'h0000_0107);
    reg_rd(BASE + 32'h0, d, k, e);
    checks++;
    if (d !== 32'h0000_0104) begin errors++; $display("FAIL src_align got %h required 00000104", d); end
    s_sel = 4'h3;
    reg_wr(BASE + 32'h0, 32'h0000_0ABC);
    s_sel = 4'hF;
    reg_rd(BASE + 32'h0, d, k, e);
    checks++;
    if (d !== 32'h0000_0104) begin errors++; $display("FAIL partial_sel got %h required 00000104", d); end
`ifndef WB_DMA_IRQ_EN
    reg_wr(BASE + 32'hC, 32'h10);
    reg_rd(BASE + 32'hC, d, k, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL irq_en_absent got %h required 0", d); end
`endif
  endtask

  task automatic test_copy(input int stall);
    logic [31:0] ctrl;
    bit to;
    op_t o, x;
    setup_copy(32'h100, 32'h200, 3);
    stall_cycles = stall;
    reg_wr(BASE + 32'hC, 32'h1);
    wait_idle(ctrl, to);
    checks++;
    if (to || ctrl !== 32'h4) begin
      errors++; $display("FAIL copy_s%0d_ctrl got %h timeout=%0d required 00000004", stall, ctrl, to);
    end
    checks++;
    if (obs_q.size() != 6) begin errors++; $display("FAIL copy_s%0d_ops got %0d required 6", stall, obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      x = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== x) begin errors++; $display("FAIL copy_s%0d_op got %h required %h", stall, o, x); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[(32'h200 >> 2) + i] !== pat[i]) begin
        errors++; $display("FAIL copy_s%0d_mem%0d got %h required %h", stall, i, mem[(32'h200 >> 2) + i], pat[i]);
      end
    end
    checks++;
    if (cyc_rises != 6) begin errors++; $display("FAIL copy_s%0d_cycles got %0d required 6", stall, cyc_rises); end
    if (stall > 0) begin
      checks++;
      if (stall_seen != 12 || adr_changes != 0 || stb_drops != 0) begin
        errors++;
        $display("FAIL stall_hold got stalls=%0d adrchg=%0d stbdrop=%0d required 12/0/0", stall_seen, adr_changes, stb_drops);
      end
    end
    stall_cycles = 0;
  endtask

  task automatic test_error;
    logic [31:0] ctrl;
    bit to;
    setup_copy(32'h100, 32'h200, 3);
    err_on_read = 2;
    reg_wr(BASE + 32'hC, 32'h1);
    wait_idle(ctrl, to);
    checks++;
    if (to || ctrl !== 32'h8) begin errors++; $display("FAIL err_ctrl got %h timeout=%0d required 00000008", ctrl, to); end
    checks++;
    if (wr_count != 1) begin errors++; $display("FAIL err_writes got %0d required 1", wr_count); end
    checks++;
    if (cyc_after_err !== 1'b0) begin errors++; $display("FAIL err_cyc_drop got %b required 0", cyc_after_err); end
    checks++;
    if (obs_q.size() != 3) begin errors++; $display("FAIL err_ops got %0d required 3", obs_q.size()); end
    err_on_read = 0;
  endtask

  task automatic test_len_zero;
    logic [31:0] d;
    logic k, e;
    setup_copy(32'h100, 32'h200, 0);
    reg_wr(BASE + 32'hC, 32'h1);
    reg_rd(BASE + 32'hC, d, k, e);
    checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL len0_done got %h required 00000004", d); end
    repeat (5) @(negedge clk);
    checks++;
    if (cyc_rises != 0) begin errors++; $display("FAIL len0_nocyc got %0d required 0", cyc_rises); end
  endtask

  task automatic test_busy_write;
    logic [31:0] d, ctrl;
    logic k, e;
    bit to;
    setup_copy(32'h100, 32'h200, 3);
    stall_cycles = 2;
    reg_wr(BASE + 32'hC, 32'h1);
    reg_wr(BASE + 32'h8, 32'h5);
    reg_wr(BASE + 32'h0, 32'h300);
    reg_rd(BASE + 32'h8, d, k, e);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL busy_len got %h required 00000003", d); end
    reg_rd(BASE + 32'h0, d, k, e);
    checks++;
    if (d !== 32'h100) begin errors++; $display("FAIL busy_src got %h required 00000100", d); end
    wait_idle(ctrl, to);
    checks++;
    if (to || ctrl !== 32'h4) begin errors++; $display("FAIL busy_done got %h timeout=%0d required 00000004", ctrl, to); end
    reg_wr(BASE + 32'hC, 32'h4);
    reg_rd(BASE + 32'hC, d, k, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL done_w1c got %h required 0", d); end
    stall_cycles = 0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic k, e;
    bit seen = 1'b0;
    setup_copy(32'h100, 32'h200, 3);
    stall_cycles = 5;
    reg_wr(BASE + 32'hC, 32'h1);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = m_stb && m_we;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rstmid_reach got no write request required one"); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (m_cyc !== 1'b0 || m_stb !== 1'b0) begin
      errors++; $display("FAIL rstmid_bus got cyc=%b stb=%b required 0/0", m_cyc, m_stb);
    end
    rst = 1'b0;
    stall_cycles = 0;
    for (int r = 0; r < 4; r++) begin
      reg_rd(BASE + 32'(4 * r), d, k, e);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL rstmid_reg%0d got %h required 0", r, d); end
    end
  endtask

`ifdef WB_DMA_IRQ_EN
  task automatic test_irq;
    logic [31:0] ctrl;
    bit to;
    setup_copy(32'h100, 32'h200, 2);
    reg_wr(BASE + 32'hC, 32'h11);
    wait_idle(ctrl, to);
    repeat (2) @(negedge clk);
    checks++;
    if (to || ctrl !== 32'h14 || irq !== 1'b1) begin
      errors++; $display("FAIL irq_set got ctrl=%h irq=%b required 00000014/1", ctrl, irq);
    end
    reg_wr(BASE + 32'hC, 32'h14);
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b required 0", irq); end
  endtask
`endif

  initial begin
    test_reset;
    test_regport;
    test_copy(0);
    test_copy(2);
    test_error;
    test_len_zero;
    test_busy_write;
`ifdef WB_DMA_IRQ_EN
    test_irq;
`endif
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
